// File: rtl/minifloat_pkg.sv
// Shared minifloat definitions: code layout and decode to integer magnitude.
// Used by the accumulator datapath and by converter/accumulator models.
package minifloat_pkg;

  localparam int MF_M_W   = 4;
  localparam int MF_E_W   = 3;
  localparam int MF_INT_W = 11;

  typedef struct packed {
    logic [MF_M_W-1:0] m;
    logic [MF_E_W-1:0] e;
  } mf_code_t;

  // Codes are truncated magnitudes, so decode is an exact shift.
  function automatic logic [MF_INT_W-1:0] mf_decode(
    input mf_code_t c
  );
    return MF_INT_W'(c.m) << c.e;
  endfunction

endpackage

// File: rtl/minifloat_decode.sv
// Combinational minifloat code to 11-bit magnitude expander.
// Shared by the accumulator and by reference models.
module minifloat_decode
  import minifloat_pkg::*;
(
  input  mf_code_t              code_i,
  output logic [MF_INT_W-1:0]   value_o
);

  assign value_o = mf_decode(code_i);

endmodule

// File: rtl/minifloat_accum.sv
// Frame accumulator: decodes minifloat codes, sums and tracks the peak
// over FRAME_LEN samples, and hands the result out on valid/ready.
module minifloat_accum
  import minifloat_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  localparam int SUM_W    = MF_INT_W + $clog2(FRAME_LEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MF_M_W-1:0]   in_m,
  input  logic [MF_E_W-1:0]   in_e,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SUM_W-1:0]    out_sum,
  output logic [MF_INT_W-1:0] out_peak
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    ACC,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [MF_INT_W-1:0] pk_q, pk_d;
  logic                vld_q, vld_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [MF_INT_W-1:0] peak_q, peak_d;

  mf_code_t            code;
  logic [MF_INT_W-1:0] value;
  logic [SUM_W-1:0]    acc_nxt;
  logic [MF_INT_W-1:0] pk_nxt;
  logic                accept;

  assign code.m = in_m;
  assign code.e = in_e;

  minifloat_decode u_dec (
    .code_i  (code),
    .value_o (value)
  );

  // Ready depends only on state, clear and reset, never on in_valid.
  assign in_ready = rst_n & ~clear & (state_q == ACC);
  assign accept   = in_valid & in_ready;

  assign acc_nxt = acc_q + SUM_W'(value);
  assign pk_nxt  = (value > pk_q) ? value : pk_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pk_d    = pk_q;
    vld_d   = vld_q;
    sum_d   = sum_q;
    peak_d  = peak_q;
    if (clear) begin
      state_d = ACC;
      cnt_d   = '0;
      acc_d   = '0;
      pk_d    = '0;
      vld_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (accept) begin
            if (cnt_q == CNT_LAST) begin
              sum_d   = acc_nxt;
              peak_d  = pk_nxt;
              vld_d   = 1'b1;
              cnt_d   = '0;
              acc_d   = '0;
              pk_d    = '0;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
              acc_d = acc_nxt;
              pk_d  = pk_nxt;
            end
          end
        end
        DONE: begin
          if (vld_q && out_ready) begin
            vld_d   = 1'b0;
            state_d = ACC;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      pk_q    <= '0;
      vld_q   <= 1'b0;
      sum_q   <= '0;
      peak_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pk_q    <= pk_d;
      vld_q   <= vld_d;
      sum_q   <= sum_d;
      peak_q  <= peak_d;
    end
  end

  assign out_valid = vld_q;
  assign out_sum   = sum_q;
  assign out_peak  = peak_q;

endmodule

// File: tb/tb_minifloat_accum.sv
// Directed frame table, back-pressure/clear/reset sequences and a
// randomized handshake run against a decode-based scoreboard.
module tb_minifloat_accum;
  import minifloat_pkg::*;

  localparam int FL  = 16;
  localparam int SW  = 15;
  localparam int BUD = 60000;

  logic          clk = 1'b0;
  logic          rst_n, clear;
  logic          in_valid, in_ready;
  logic [3:0]    in_m;
  logic [2:0]    in_e;
  logic          out_valid, out_ready;
  logic [SW-1:0] out_sum;
  logic [10:0]   out_peak;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  minifloat_accum #(.FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_m      (in_m),
    .in_e      (in_e),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_peak  (out_peak)
  );

  typedef struct {
    logic [3:0]  m;
    logic [2:0]  e;
    int          sum;
    int          peak;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm,
                     input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one code repeatedly until n accepts, bounded.
  task automatic feed(input logic [3:0] m,
                      input logic [2:0] e, input int n);
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    in_valid = 1'b1;
    in_m = m;
    in_e = e;
    while (sent < n && guard < 200) begin
      #1;
      if (in_ready) sent++;
      step();
      guard++;
    end
    in_valid = 1'b0;
    if (sent < n) chk("feed_timeout", sent, n);
  endtask

  initial begin
    int acc;
    int pk;
    int cnt;
    int frames;
    int cyc;
    int v;
    int q_sum[$];
    int q_pk[$];
    mf_code_t c;

    vt[0] = '{4'd15, 3'd7, 30720, 1920};
    vt[1] = '{4'd0,  3'd0, 0,     0};
    vt[2] = '{4'd9,  3'd3, 1152,  72};
    vt[3] = '{4'd2,  3'd1, 64,    4};
    vt[4] = '{4'd1,  3'd0, 16,    1};

    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_m = '0;
    in_e = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    step();
    step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_peak", int'(out_peak), 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", int'(in_ready), 1);

    // Uniform frames with out_ready high.
    for (int i = 0; i < 5; i++) begin
      feed(vt[i].m, vt[i].e, FL);
      chk("tbl_valid", int'(out_valid), 1);
      chk("tbl_sum", int'(out_sum), vt[i].sum);
      chk("tbl_peak", int'(out_peak), vt[i].peak);
      chk("tbl_ready_done", int'(in_ready), 0);
      step();
      chk("tbl_valid_1cyc", int'(out_valid), 0);
      chk("tbl_ready_back", int'(in_ready), 1);
    end

    // Back-pressure: 5 * 4 = 20 per sample.
    out_ready = 1'b0;
    feed(4'd5, 3'd2, FL);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_sum", int'(out_sum), 320);
      chk("bp_peak", int'(out_peak), 20);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_valid_drop", int'(out_valid), 0);
    chk("bp_ready_back", int'(in_ready), 1);

    // Clear after a partial frame; code in clear cycle dropped.
    feed(4'd15, 3'd7, 5);
    clear = 1'b1;
    in_valid = 1'b1;
    in_m = 4'd15;
    in_e = 3'd7;
    #1;
    chk("clr_ready", int'(in_ready), 0);
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    feed(4'd1, 3'd0, FL);
    chk("clr_valid", int'(out_valid), 1);
    chk("clr_sum", int'(out_sum), 16);
    chk("clr_peak", int'(out_peak), 1);
    step();

    // Clear while a result is pending.
    out_ready = 1'b0;
    feed(4'd3, 3'd0, FL);
    chk("clrd_valid", int'(out_valid), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    out_ready = 1'b1;
    chk("clrd_drop", int'(out_valid), 0);
    #1;
    chk("clrd_ready", int'(in_ready), 1);

    // Reset mid-frame.
    feed(4'd2, 3'd1, 8);
    rst_n = 1'b0;
    #1;
    chk("rstm_ready", int'(in_ready), 0);
    step();
    rst_n = 1'b1;
    chk("rstm_valid", int'(out_valid), 0);
    chk("rstm_sum", int'(out_sum), 0);
    chk("rstm_peak", int'(out_peak), 0);

    // Reset while result pending.
    out_ready = 1'b0;
    feed(4'd2, 3'd1, FL);
    chk("rstd_sum_pre", int'(out_sum), 64);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("rstd_valid", int'(out_valid), 0);
    chk("rstd_sum", int'(out_sum), 0);
    chk("rstd_peak", int'(out_peak), 0);
    feed(4'd2, 3'd1, FL);
    chk("rstd_next_sum", int'(out_sum), 64);
    chk("rstd_next_peak", int'(out_peak), 4);
    step();

    // Random handshake run against a scoreboard.
    acc = 0;
    pk = 0;
    cnt = 0;
    frames = 0;
    cyc = 0;
    while (frames < 1000 && cyc < BUD) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = $urandom_range(1) == 1;
      in_m = 4'($urandom_range(15));
      in_e = 3'($urandom_range(7));
      #1;
      if (in_valid && in_ready) begin
        c.m = in_m;
        c.e = in_e;
        v = int'(mf_decode(c));
        acc += v;
        if (v > pk) pk = v;
        cnt++;
        if (cnt == FL) begin
          q_sum.push_back(acc);
          q_pk.push_back(pk);
          acc = 0;
          pk = 0;
          cnt = 0;
        end
      end
      if (out_valid && out_ready) begin
        if (q_sum.size() == 0) begin
          chk("rnd_spurious", 1, 0);
        end else begin
          chk("rnd_sum", int'(out_sum), q_sum.pop_front());
          chk("rnd_peak", int'(out_peak), q_pk.pop_front());
        end
        frames++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rnd_frames", frames, 1000);
    chk("rnd_leftover", q_sum.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/minifloat_accum.md
# minifloat_accum

Downstream consumer of the 11-bit integer-to-minifloat converter. Accepts one 7-bit minifloat code per handshake, expands it back to an 11-bit integer magnitude, and accumulates a frame of FRAME_LEN samples. Presents the frame sum and the frame peak on a valid/ready output. Sits between the combinational converter output (M[3:0], E[2:0]) and the frame-statistics consumer.

## Interface
- FRAME_LEN, 16, samples per frame; integer ≥ 2.
- SUM_W, 11 + $clog2(FRAME_LEN), localparam; output sum width, sized so overflow is impossible.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- clear  in  1  synchronous frame abort.
- in_valid  in  1  input code valid.
- in_ready  out  1  block can accept a code.
- in_m  in  4  mantissa M[3:0].
- in_e  in  3  exponent E[2:0].
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  SUM_W  sum of decoded samples in frame.
- out_peak  out  11  largest decoded sample in frame.

## Operation
- Decode: value = zero-extend(in_m) << in_e, 11 bits, max 15<<7 = 1920. No rounding; codes are taken as truncated magnitudes.
- State register: ACC, DONE. Counter cnt (0..FRAME_LEN-1), accumulator acc (SUM_W), peak register pk (11).
- ACC: in_ready = 1. On accept (in_valid & in_ready): acc += value, pk = max(pk, value), cnt++. If cnt == FRAME_LEN-1 on accept: out_sum ← acc+value, out_peak ← max(pk,value), out_valid ← 1, cnt/acc/pk ← 0, state → DONE.
- DONE: in_ready = 0; out_sum/out_peak held stable while out_valid = 1. On out_valid & out_ready: out_valid ← 0, state → ACC.
- clear (rst_n high): next cycle state = ACC, cnt/acc/pk = 0, out_valid = 0; partial frame and any pending result discarded; a code offered in the clear cycle is not accepted (in_ready forced 0 while clear = 1).
- Priority: rst_n low > clear > handshake activity.
- Reset (rst_n sampled low): state = ACC, cnt = 0, acc = 0, pk = 0, out_valid = 0, out_sum = 0, out_peak = 0. in_ready = 0 while rst_n low, 1 from the first cycle after rst_n sampled high. Reset mid-frame or mid-DONE discards everything.
- in_m/in_e ignored when not accepted; out_ready ignored when out_valid = 0.

## Timing
- Throughput: one sample per cycle in ACC; one bubble cycle per frame (DONE→ACC after output handshake), so FRAME_LEN+1 cycles per frame minimum with out_ready tied high.
- Latency: out_valid rises the cycle after the last sample's accept edge.
- in_ready is combinational from state, clear and rst_n only; never from in_valid.
- out_valid, out_sum, out_peak are registered outputs.
- First sample of the next frame can be accepted in the cycle after the output handshake cycle.

## Structure
- Package minifloat_pkg: MF_M_W = 4, MF_E_W = 3, MF_INT_W = 11, packed struct mf_code_t {m, e}, function mf_decode (code → 11-bit value). The same package is used by the converter testbench golden model.
- Sub-module minifloat_decode: combinational mf_code_t → 11-bit value wrapper around mf_decode, reused by the verification reference model.
- State enum local to the module.

## Test plan
- FRAME_LEN=16, 16 codes E=7 M=15, out_ready=1 → out_sum = 30720, out_peak = 1920, out_valid one cycle after 16th accept, for exactly one cycle.
- 16 codes E=0 M=0 → out_sum = 0, out_peak = 0; next frame of E=3 M=9 ×16 → out_sum = 1152, out_peak = 72.
- Back-pressure: complete frame, hold out_ready low 5 cycles → in_ready = 0, out_sum/out_peak unchanged all 5 cycles; raise out_ready → out_valid drops next cycle, in_ready = 1 the cycle after the handshake.
- clear after 5 accepted samples of 1920, then 16 codes E=0 M=1 → out_sum = 16, out_peak = 1; code presented during the clear cycle not counted.
- rst_n low for 1 cycle mid-frame (8 samples in) and again while out_valid = 1 → all outputs 0; next full frame of E=1 M=2 sums to 64.
- Random in_valid/out_ready toggling over 1000 frames vs. mf_decode-based model → sums and peaks match, no sample lost or duplicated.
